// File: rtl/script_executor.sv
// Script memory sequencer: fetches 16-bit instructions by pc, issues operate
// bytes over a valid/ready handshake, and waits on ms ticks or feedback flags.
module script_executor (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        script_mode,
    input  logic [15:0] script,
    input  logic        tick_ms,
    input  logic        sig_front,
    input  logic        sig_hand,
    input  logic        sig_processing,
    input  logic        sig_machine,
    input  logic        op_ready,
    output logic [7:0]  pc,
    output logic [7:0]  op_bits,
    output logic        op_valid,
    output logic        running,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        TWAIT,
        SWAIT,
        HALT
    } state_t;

    localparam logic [3:0] OP_END   = 4'h0;
    localparam logic [3:0] OP_ACT   = 4'h1;
    localparam logic [3:0] OP_WAITT = 4'h2;
    localparam logic [3:0] OP_JMP   = 4'h3;
    localparam logic [3:0] OP_WAITS = 4'h4;
    localparam logic [3:0] OP_JSIG  = 4'h5;

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  ir_sel;
    logic        ir_pol;
    logic [3:0]  flags;
    logic [7:0]  pc_step;
    logic [7:0]  jump_target;
    logic        live_match;
    logic        held_match;
    logic        unused_script_bit;

    assign flags             = {sig_machine, sig_processing, sig_hand, sig_front};
    assign pc_step           = pc + 8'd2;
    assign jump_target       = {script[15:9], 1'b0};
    assign live_match        = (flags[script[5:4]] == script[6]);
    assign held_match        = (flags[ir_sel] == ir_pol);
    assign unused_script_bit = script[7];

    // DECODE acts on the live script word; only the flag select/polarity is
    // kept for SWAIT, since every other field is consumed in that same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= 8'h00;
            op_bits  <= 8'h00;
            op_valid <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
            cnt      <= 8'h00;
            ir_sel   <= 2'b00;
            ir_pol   <= 1'b0;
        end else if (script_mode) begin
            state    <= IDLE;
            pc       <= 8'h00;
            op_valid <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
            cnt      <= 8'h00;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state   <= FETCH;
                        pc      <= 8'h00;
                        running <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    ir_sel <= script[5:4];
                    ir_pol <= script[6];
                    case (script[3:0])
                        OP_END: begin
                            state   <= HALT;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                        OP_ACT: begin
                            state    <= SEND;
                            op_bits  <= script[15:8];
                            op_valid <= 1'b1;
                        end
                        OP_WAITT: begin
                            if (script[15:8] == 8'h00) begin
                                pc    <= pc_step;
                                state <= FETCH;
                            end else begin
                                cnt   <= script[15:8];
                                state <= TWAIT;
                            end
                        end
                        OP_JMP: begin
                            pc    <= jump_target;
                            state <= FETCH;
                        end
                        OP_WAITS: state <= SWAIT;
                        OP_JSIG: begin
                            pc    <= live_match ? jump_target : pc_step;
                            state <= FETCH;
                        end
                        default: begin
                            pc    <= pc_step;
                            state <= FETCH;
                        end
                    endcase
                end
                SEND: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        pc       <= pc_step;
                        state    <= FETCH;
                    end
                end
                TWAIT: begin
                    if (tick_ms) begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            pc    <= pc_step;
                            state <= FETCH;
                        end
                    end
                end
                SWAIT: begin
                    if (held_match) begin
                        pc    <= pc_step;
                        state <= FETCH;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_script_executor.sv
// Bench for script_executor: decode vector table, hand-written multi-cycle
// sequences, and random loop-free programs against an instruction-level model.
module tb_script_executor;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        script_mode;
    logic [15:0] script;
    logic        tick_ms;
    logic        sig_front;
    logic        sig_hand;
    logic        sig_processing;
    logic        sig_machine;
    logic        op_ready;
    logic [7:0]  pc;
    logic [7:0]  op_bits;
    logic        op_valid;
    logic        running;
    logic        done;

    logic [15:0] mem [0:127];
    logic [7:0]  exp_ops [$];
    logic [7:0]  got_ops [$];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  sigs;
        logic [7:0]  exp_pc;
        logic        exp_valid;
        logic [7:0]  exp_bits;
        logic        exp_running;
        logic        exp_done;
    } vec_t;

    vec_t vecs [16];

    script_executor dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .script_mode(script_mode),
        .script(script),
        .tick_ms(tick_ms),
        .sig_front(sig_front),
        .sig_hand(sig_hand),
        .sig_processing(sig_processing),
        .sig_machine(sig_machine),
        .op_ready(op_ready),
        .pc(pc),
        .op_bits(op_bits),
        .op_valid(op_valid),
        .running(running),
        .done(done)
    );

    always #5 clock = ~clock;

    // Script memory with one cycle of read latency, word-addressed by pc.
    always @(posedge clock) script <= mem[pc[7:1]];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic setSigs(input logic [3:0] s);
        {sig_machine, sig_processing, sig_hand, sig_front} = s;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    endtask

    task automatic abortToIdle();
        script_mode = 1'b1;
        step();
        script_mode = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] instr, input logic [3:0] s);
        clearMem();
        mem[0] = instr;
        setSigs(s);
        abortToIdle();
    endtask

    task automatic waitValid(input string name, input int budget, output int cyc);
        cyc = 0;
        while (!op_valid && cyc < budget) begin
            step();
            cyc++;
        end
        if (!op_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: op_valid timeout after %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic waitDone(input string name, input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            step();
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: done timeout after %0d cycles, required 1", name, budget);
        end
    endtask

    // Instruction-level interpretation of the program in mem; timing is ignored.
    function automatic logic [7:0] modelRun(input logic [3:0] s);
        logic [7:0]  p;
        logic [15:0] w;
        p = 8'h00;
        exp_ops.delete();
        for (int n = 0; n < 300; n++) begin
            w = mem[p[7:1]];
            case (w[3:0])
                4'h0: return p;
                4'h1: begin
                    exp_ops.push_back(w[15:8]);
                    p = p + 8'd2;
                end
                4'h3: p = w[15:8] & 8'hFE;
                4'h4: begin
                    if (s[w[5:4]] != w[6]) return 8'hFF;
                    p = p + 8'd2;
                end
                4'h5: p = (s[w[5:4]] == w[6]) ? (w[15:8] & 8'hFE) : (p + 8'd2);
                default: p = p + 8'd2;
            endcase
        end
        return 8'hFF;
    endfunction

    // Jumps only go forward and WAITS always matches, so every program ends.
    task automatic genProgram(input int n, input logic [3:0] s);
        logic [1:0] sel;
        logic       pol;
        logic       b7;
        logic [7:0] arg;
        logic [7:0] t8;
        logic [7:0] targ;
        for (int i = 0; i < n - 1; i++) begin
            sel  = 2'($urandom_range(0, 3));
            pol  = 1'($urandom_range(0, 1));
            b7   = 1'($urandom_range(0, 1));
            arg  = 8'($urandom_range(0, 255));
            t8   = 8'($urandom_range(i + 1, n - 1));
            targ = {t8[6:0], 1'($urandom_range(0, 1))};
            case ($urandom_range(0, 5))
                0: mem[i] = {arg, b7, pol, sel, 4'h1};
                1: mem[i] = {8'($urandom_range(0, 3)), b7, pol, sel, 4'h2};
                2: mem[i] = {targ, b7, pol, sel, 4'h3};
                3: mem[i] = {arg, b7, s[sel], sel, 4'h4};
                4: mem[i] = {targ, b7, pol, sel, 4'h5};
                default: mem[i] = {arg, b7, pol, sel, 4'($urandom_range(6, 15))};
            endcase
        end
        mem[n - 1] = {12'($urandom_range(0, 4095)), 4'h0};
    endtask

    task automatic runRandom(input int idx);
        int         n;
        logic [3:0] s;
        logic [7:0] exp_pc;
        int         cyc;
        n = $urandom_range(3, 10);
        s = 4'($urandom_range(0, 15));
        clearMem();
        genProgram(n, s);
        exp_pc = modelRun(s);
        got_ops.delete();
        setSigs(s);
        abortToIdle();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            op_ready = 1'($urandom_range(0, 1));
            tick_ms  = ((cyc % 4) == 3);
            if (op_valid && op_ready) got_ops.push_back(op_bits);
            step();
            cyc++;
        end
        op_ready = 1'b0;
        tick_ms  = 1'b0;
        checkOutput($sformatf("rnd%0d_done", idx), done, 1'b1);
        checkOutput($sformatf("rnd%0d_pc", idx), pc, exp_pc);
        checkOutput($sformatf("rnd%0d_nops", idx), 16'(got_ops.size()), 16'(exp_ops.size()));
        for (int k = 0; k < exp_ops.size() && k < got_ops.size(); k++)
            checkOutput($sformatf("rnd%0d_op%0d", idx, k), got_ops[k], exp_ops[k]);
    endtask

    initial begin
        int cyc;
        vecs[0]  = '{16'h0000, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[1]  = '{16'h1D01, 4'h0, 8'h00, 1'b1, 8'h1D, 1'b1, 1'b0};
        vecs[2]  = '{16'h0302, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{16'h0002, 4'h0, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{16'h0703, 4'h0, 8'h06, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{16'hFF83, 4'h0, 8'hFE, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{16'h0745, 4'h1, 8'h06, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{16'h0745, 4'h0, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{16'h0755, 4'h2, 8'h06, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{16'h0835, 4'h0, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{16'h0835, 4'h8, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{16'h0F06, 4'h0, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{16'h0024, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{16'h0F8E, 4'h0, 8'h02, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[14] = '{16'hA501, 4'h0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[15] = '{16'h00F5, 4'h8, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};

        reset       = 1'b1;
        start       = 1'b0;
        script_mode = 1'b0;
        tick_ms     = 1'b0;
        op_ready    = 1'b0;
        setSigs(4'h0);
        clearMem();
        step();
        step();
        checkOutput("reset_pc", pc, 8'h00);
        checkOutput("reset_op_bits", op_bits, 8'h00);
        checkOutput("reset_op_valid", op_valid, 1'b0);
        checkOutput("reset_running", running, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        reset = 1'b0;

        // Single-instruction decode: outputs right after the DECODE edge.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].instr, vecs[i].sigs);
            checkOutput($sformatf("vec%0d_idle", i), {pc, op_valid, running, done}, 16'h0000);
            start = 1'b1;
            step();
            start = 1'b0;
            step();
            step();
            checkOutput($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d_valid", i), op_valid, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d_running", i), running, vecs[i].exp_running);
            checkOutput($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
            if (vecs[i].exp_valid) checkOutput($sformatf("vec%0d_bits", i), op_bits, vecs[i].exp_bits);
        end

        // ACT with a slow receiver, then END, then a restart from HALT.
        applyStimulus(16'h1D01, 4'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        waitValid("act_rise", 10, cyc);
        checkOutput("act_latency", 16'(cyc), 16'd2);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("act_hold%0d_valid", k), op_valid, 1'b1);
            checkOutput($sformatf("act_hold%0d_bits", k), op_bits, 8'h1D);
            checkOutput($sformatf("act_hold%0d_pc", k), pc, 8'h00);
            start    = (k == 1);
            op_ready = (k == 3);
            step();
        end
        start    = 1'b0;
        op_ready = 1'b0;
        checkOutput("act_drop_valid", op_valid, 1'b0);
        checkOutput("act_drop_pc", pc, 8'h02);
        step();
        checkOutput("act_decode_done", done, 1'b0);
        step();
        checkOutput("act_halt_done", done, 1'b1);
        checkOutput("act_halt_pc", pc, 8'h02);
        checkOutput("act_halt_running", running, 1'b0);
        step();
        checkOutput("act_halt_pc_hold", pc, 8'h02);
        op_ready = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        checkOutput("act_restart_pc", pc, 8'h00);
        checkOutput("act_restart_done", done, 1'b0);
        waitValid("act_resend", 10, cyc);
        checkOutput("act_resend_latency", 16'(cyc), 16'd2);
        checkOutput("act_resend_bits", op_bits, 8'h1D);
        step();
        op_ready = 1'b0;
        checkOutput("act_resend_drop", op_valid, 1'b0);
        checkOutput("act_resend_pc", pc, 8'h02);

        // WAITT 3: the tick during DECODE must not count.
        applyStimulus(16'h0302, 4'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        tick_ms = 1'b1;
        step();
        tick_ms = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            step();
            step();
            step();
            tick_ms = 1'b1;
            step();
            tick_ms = 1'b0;
            checkOutput($sformatf("waitt_tick%0d_pc", t), pc, (t < 3) ? 8'h00 : 8'h02);
        end
        checkOutput("waitt_running", running, 1'b1);
        step();
        step();
        checkOutput("waitt_done", done, 1'b1);
        checkOutput("waitt_done_pc", pc, 8'h02);

        applyStimulus(16'h0002, 4'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        waitDone("waitt0_done", 10, cyc);
        checkOutput("waitt0_cycles", 16'(cyc), 16'd4);
        checkOutput("waitt0_pc", pc, 8'h02);

        // WAITS on sig_hand, then ACT 0x05.
        applyStimulus(16'h0054, 4'h0);
        mem[1] = 16'h0501;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (50) step();
        checkOutput("waits_hold_pc", pc, 8'h00);
        checkOutput("waits_hold_valid", op_valid, 1'b0);
        checkOutput("waits_hold_running", running, 1'b1);
        sig_hand = 1'b1;
        waitValid("waits_rise", 10, cyc);
        checkOutput("waits_latency", 16'(cyc), 16'd3);
        checkOutput("waits_bits", op_bits, 8'h05);
        checkOutput("waits_pc", pc, 8'h02);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        waitDone("waits_done", 10, cyc);
        checkOutput("waits_end_pc", pc, 8'h04);

        // JMP to 0xFE, NOP there wraps pc to 0x00 and execution continues.
        applyStimulus(16'hFE03, 4'h0);
        mem[127] = 16'h0006;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checkOutput("wrap_jmp_pc", pc, 8'hFE);
        step();
        step();
        checkOutput("wrap_nop_pc", pc, 8'h00);
        step();
        step();
        checkOutput("wrap_again_pc", pc, 8'hFE);
        checkOutput("wrap_running", running, 1'b1);

        // script_mode during SEND overrides a simultaneous op_ready.
        applyStimulus(16'h1D01, 4'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        waitValid("abort_rise", 10, cyc);
        script_mode = 1'b1;
        op_ready    = 1'b1;
        step();
        op_ready = 1'b0;
        checkOutput("abort_valid", op_valid, 1'b0);
        checkOutput("abort_pc", pc, 8'h00);
        checkOutput("abort_running", running, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("abort_start_ignored", running, 1'b0);
        script_mode = 1'b0;
        step();
        checkOutput("abort_still_idle", running, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("abort_restart_running", running, 1'b1);
        checkOutput("abort_restart_pc", pc, 8'h00);
        waitValid("abort_resend", 10, cyc);
        checkOutput("abort_resend_bits", op_bits, 8'h1D);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        waitDone("abort_done_end", 10, cyc);
        checkOutput("abort_end_pc", pc, 8'h02);

        // reset outranks start and returns to the reset state.
        applyStimulus(16'h0703, 4'h0);
        start = 1'b1;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        checkOutput("reset_prio_running", running, 1'b0);
        checkOutput("reset_prio_pc", pc, 8'h00);
        checkOutput("reset_prio_bits", op_bits, 8'h00);

        for (int r = 0; r < 15; r++) runRandom(r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
